// File: rtl/scct_pin_filter.sv
// Per-channel pin conditioning: two-flop synchronizer, programmable pulse-rejection
// filter paced by a tick, and single-cycle rise/fall/glitch strobes.
module scct_pin_filter #(
    parameter int N_CHANNELS = 8,
    parameter int FILT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CHANNELS-1:0] pins_raw,
    input  logic [N_CHANNELS-1:0] filt_en,
    input  logic [FILT_W-1:0]     filt_len,
    input  logic                  tick,
    output logic [N_CHANNELS-1:0] pins_f,
    output logic [N_CHANNELS-1:0] rise,
    output logic [N_CHANNELS-1:0] fall,
    output logic [N_CHANNELS-1:0] glitch
);

    logic [N_CHANNELS-1:0] ff1;
    logic [N_CHANNELS-1:0] s;
    logic [FILT_W-1:0]     cnt      [N_CHANNELS];
    logic [FILT_W-1:0]     cnt_next [N_CHANNELS];
    logic [N_CHANNELS-1:0] f_next;
    logic [N_CHANNELS-1:0] glitch_next;

    // Filter decision per channel; a returning level takes priority over acceptance.
    always_comb begin
        f_next      = pins_f;
        glitch_next = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            cnt_next[i] = cnt[i];
            if (!filt_en[i]) begin
                f_next[i]   = s[i];
                cnt_next[i] = '0;
            end else if (s[i] == pins_f[i]) begin
                cnt_next[i]    = '0;
                glitch_next[i] = (cnt[i] != '0);
            end else if (tick) begin
                if (cnt[i] >= filt_len) begin
                    f_next[i]   = s[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + FILT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1    <= '0;
            s      <= '0;
            pins_f <= '0;
            rise   <= '0;
            fall   <= '0;
            glitch <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            ff1    <= pins_raw;
            s      <= ff1;
            pins_f <= f_next;
            rise   <= ~pins_f & f_next;
            fall   <= pins_f & ~f_next;
            glitch <= glitch_next;
            for (int i = 0; i < N_CHANNELS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_scct_pin_filter.sv
// Bench for scct_pin_filter: per-cycle comparison against a behavioural model,
// plus directed scenarios with hand-computed edge timing.
module tb_scct_pin_filter;

    localparam int N = 8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] pins_raw = '0;
    logic [N-1:0] filt_en  = '0;
    logic [W-1:0] filt_len = '0;
    logic         tick     = 1'b1;
    logic [N-1:0] pins_f, rise, fall, glitch;

    int n_checks = 0;
    int n_pass   = 0;

    scct_pin_filter #(.N_CHANNELS(N), .FILT_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pins_raw (pins_raw),
        .filt_en  (filt_en),
        .filt_len (filt_len),
        .tick     (tick),
        .pins_f   (pins_f),
        .rise     (rise),
        .fall     (fall),
        .glitch   (glitch)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: pins reach the filter two samples late; a new level is
    // accepted on the (L+1)-th tick it has been seen, or dropped if it vanishes.
    logic [N-1:0] raw_q[$] = '{8'h00, 8'h00};
    logic [N-1:0] m_f = '0, m_rise = '0, m_fall = '0, m_glitch = '0;
    int           ticks_seen[N];
    bit           model_on = 0;

    always @(posedge clk) begin
        logic [N-1:0] s_now;
        logic [N-1:0] old_f;
        if (rst) begin
            raw_q = '{8'h00, 8'h00};
            m_f = '0; m_rise = '0; m_fall = '0; m_glitch = '0;
            for (int i = 0; i < N; i++) ticks_seen[i] = 0;
            model_on = 1;
        end else begin
            s_now = raw_q.pop_front();
            raw_q.push_back(pins_raw);
            old_f = m_f;
            m_glitch = '0;
            for (int i = 0; i < N; i++) begin
                if (!filt_en[i]) begin
                    m_f[i] = s_now[i];
                    ticks_seen[i] = 0;
                end else if (s_now[i] == old_f[i]) begin
                    m_glitch[i] = (ticks_seen[i] > 0);
                    ticks_seen[i] = 0;
                end else if (tick) begin
                    ticks_seen[i] = ticks_seen[i] + 1;
                    if (ticks_seen[i] > int'(filt_len)) begin
                        m_f[i] = s_now[i];
                        ticks_seen[i] = 0;
                    end
                end
            end
            m_rise = m_f & ~old_f;
            m_fall = ~m_f & old_f;
        end
        #1;
        if (model_on) begin
            chk("model_pins_f", 32'(pins_f), 32'(m_f));
            chk("model_rise",   32'(rise),   32'(m_rise));
            chk("model_fall",   32'(fall),   32'(m_fall));
            chk("model_glitch", 32'(glitch), 32'(m_glitch));
        end
    end

    // driver tasks
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        edges(2);
        chk("reset_pins_f", 32'(pins_f), 32'h0);
        chk("reset_rise",   32'(rise),   32'h0);
        rst = 1'b0;

        // bypass latency: three edges
        pins_raw[0] = 1'b1;
        edges(2);
        chk("byp_before", 32'(pins_f[0]), 32'h0);
        edges(1);
        chk("byp_pins_f", 32'(pins_f[0]), 32'h1);
        chk("byp_rise",   32'(rise[0]),   32'h1);
        edges(1);
        chk("byp_rise_low", 32'(rise[0]), 32'h0);
        pins_raw[0] = 1'b0;
        edges(5);

        // 3-cycle pulse rejected with L=3
        filt_en  = 8'hFE;
        filt_len = 8'd3;
        pins_raw[1] = 1'b1;
        edges(3);
        pins_raw[1] = 1'b0;
        edges(3);
        chk("pulse_glitch", 32'(glitch[1]), 32'h1);
        chk("pulse_pins_f", 32'(pins_f[1]), 32'h0);
        edges(1);
        chk("pulse_glitch_low", 32'(glitch[1]), 32'h0);
        edges(3);

        // steady level accepted at edge 6
        pins_raw[1] = 1'b1;
        edges(5);
        chk("l3_rise_before", 32'(pins_f[1]), 32'h0);
        edges(1);
        chk("l3_pins_f", 32'(pins_f[1]), 32'h1);
        chk("l3_rise",   32'(rise[1]),   32'h1);
        edges(1);
        chk("l3_rise_low", 32'(rise[1]), 32'h0);
        pins_raw[1] = 1'b0;
        edges(5);
        chk("l3_fall_before", 32'(fall[1]), 32'h0);
        edges(1);
        chk("l3_fall",       32'(fall[1]),   32'h1);
        chk("l3_fall_level", 32'(pins_f[1]), 32'h0);
        edges(3);

        // tick every 4th clock, L=2: accepted on the third tick (edge 12)
        filt_len = 8'd2;
        pins_raw[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick = (k % 4 == 0);
            @(negedge clk);
            if (k == 11) chk("tick_before", 32'(pins_f[2]), 32'h0);
            if (k == 12) begin
                chk("tick_pins_f", 32'(pins_f[2]), 32'h1);
                chk("tick_rise",   32'(rise[2]),   32'h1);
            end
        end
        tick = 1'b1;
        pins_raw[2] = 1'b0;
        edges(8);

        // lowering L mid-count accepts on the next tick
        filt_len = 8'd200;
        pins_raw[3] = 1'b1;
        edges(50);
        chk("lower_before", 32'(pins_f[3]), 32'h0);
        filt_len = 8'd10;
        edges(1);
        chk("lower_pins_f", 32'(pins_f[3]), 32'h1);

        // reset mid-count discards pending changes
        filt_len = 8'd200;
        pins_raw[3] = 1'b0;
        pins_raw[4] = 1'b1;
        edges(20);
        rst = 1'b1;
        edges(1);
        chk("rst_pins_f", 32'(pins_f), 32'h0);
        chk("rst_fall",   32'(fall),   32'h0);
        chk("rst_glitch", 32'(glitch), 32'h0);
        rst = 1'b0;
        filt_len = 8'd3;
        edges(5);
        chk("rst_restart_before", 32'(pins_f[4]), 32'h0);
        edges(1);
        chk("rst_restart", 32'(pins_f[4]), 32'h1);
        pins_raw[4] = 1'b0;
        edges(8);

        // disabling the filter mid-count follows s on the next edge
        filt_len = 8'd200;
        pins_raw[5] = 1'b1;
        edges(10);
        filt_en[5] = 1'b0;
        edges(1);
        chk("en_off_pins_f", 32'(pins_f[5]), 32'h1);
        chk("en_off_glitch", 32'(glitch[5]), 32'h0);
        pins_raw[5] = 1'b0;
        edges(4);

        // all channels together, L=1
        filt_en  = 8'hFF;
        filt_len = 8'd1;
        pins_raw = 8'hFF;
        edges(3);
        chk("all_before", 32'(pins_f), 32'h0);
        edges(1);
        chk("all_pins_f", 32'(pins_f), 32'hFF);
        chk("all_rise",   32'(rise),   32'hFF);
        edges(1);
        chk("all_rise_low", 32'(rise), 32'h0);
        edges(2);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
